// File: rtl/bp_fe_bht_ctrl.sv
// bp_fe_bht_ctrl
//   Sequencer and arbiter in front of the front-end branch history table.
//   It holds the BHT in reset through a short post-reset window.
//   It gates fetch lookups onto the BHT read port.
//   It queues backend resolution updates and drains them to the BHT write port.
//   A lookup and an update that target the same entry in the same cycle are
//   separated: the write waits. After max_defer_p waits, lookups are stalled
//   for one cycle so the write can go.
//
// Ports
//   clk_i, reset_n_i                          clock, async active-low reset
//   lookup_v_i, lookup_idx_i, lookup_ready_o  fetch lookup handshake
//   predict_v_o, predict_o                    prediction, one cycle after accept
//   upd_v_i, upd_idx_i, upd_correct_i         backend update request
//   upd_ready_o                               update queue has room
//   flush_i                                   discard all queued updates
//   bht_reset_o                               synchronous reset to the BHT
//   bht_r_v_o, bht_idx_r_o                    BHT read port
//   bht_w_v_o, bht_idx_w_o, bht_correct_o     BHT write port
//   bht_predict_i                             BHT read data (cycle after read)
//
// state  | meaning
// -------+-------------------------------------------------------------
// RESET  | reset asserted; BHT held in reset, nothing accepted
// HOLD   | BHT init window; updates may queue, no lookups or writes
// RUN    | normal operation; lookups accepted, queued updates drain

module bp_fe_bht_ctrl #(
  parameter int vaddr_width_p   = 39,
  parameter int bht_idx_width_p = 9,
  parameter int upd_els_p       = 4,
  parameter int max_defer_p     = 3,
  parameter int hold_cycles_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       lookup_v_i,
  input  logic [bht_idx_width_p-1:0] lookup_idx_i,
  output logic                       lookup_ready_o,
  output logic                       predict_v_o,
  output logic                       predict_o,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  output logic                       upd_ready_o,
  input  logic                       flush_i,
  output logic                       bht_reset_o,
  output logic                       bht_r_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_r_o,
  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_w_o,
  output logic                       bht_correct_o,
  input  logic                       bht_predict_i
);

  localparam int ptr_w_lp   = $clog2(upd_els_p);
  localparam int cnt_w_lp   = ptr_w_lp + 1;
  localparam int defer_w_lp = $clog2(max_defer_p + 1);
  localparam int hold_w_lp  = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;

  // The address width only matters to the parent's wiring.
  if (vaddr_width_p < 1) begin : g_vaddr_unused
  end

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_hold  = 2'd1,
    e_run   = 2'd2
  } state_e;

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       correct;
  } upd_entry_s;

  state_e               state_r, state_n;
  logic [hold_w_lp-1:0] hold_cnt_r, hold_cnt_n;

  upd_entry_s           fifo_mem [upd_els_p];
  logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]  cnt_r;
  logic [defer_w_lp-1:0] defer_r;
  logic                 pv_r;

  logic       run;
  logic       empty;
  logic       full;
  logic       force_w;
  logic       conflict;
  logic       issue;
  logic       push;
  logic       blocked;
  upd_entry_s head;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_reset;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      hold_cnt_r <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    hold_cnt_n = hold_cnt_r;
    case (state_r)
      e_reset: begin
        state_n    = e_hold;
        hold_cnt_n = hold_w_lp'(hold_cycles_p - 1);
      end
      e_hold: begin
        if (hold_cnt_r == '0) state_n = e_run;
        else                  hold_cnt_n = hold_cnt_r - 1'b1;
      end
      e_run:   state_n = e_run;
      default: state_n = e_reset;
    endcase
  end

  // ---------------- arbitration ----------------
  assign run   = (state_r == e_run);
  assign empty = (cnt_r == '0);
  assign full  = (cnt_r == cnt_w_lp'(upd_els_p));
  assign head  = fifo_mem[rd_ptr_r];

  // A saturated defer count stalls lookups, which removes the conflict.
  assign force_w        = ~empty & (defer_r == defer_w_lp'(max_defer_p));
  assign lookup_ready_o = run & ~force_w;
  assign bht_r_v_o      = lookup_v_i & lookup_ready_o;
  assign bht_idx_r_o    = lookup_idx_i;

  assign conflict = bht_r_v_o & (lookup_idx_i == head.idx);
  assign issue    = run & ~empty & (~conflict | force_w) & ~flush_i;
  assign blocked  = run & ~empty & conflict & ~force_w;

  assign bht_w_v_o     = issue;
  assign bht_idx_w_o   = head.idx;
  assign bht_correct_o = head.correct;

  assign upd_ready_o = (state_r != e_reset) & ~full;
  assign push        = upd_v_i & upd_ready_o & ~flush_i;

  assign bht_reset_o = ~run;
  assign predict_v_o = pv_r;
  assign predict_o   = pv_r & bht_predict_i;

  // ---------------- update queue ----------------
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_r] <= '{idx: upd_idx_i, correct: upd_correct_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      defer_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      defer_r  <= '0;
    end else begin
      if (push)  wr_ptr_r <= wr_ptr_r + 1'b1;
      if (issue) rd_ptr_r <= rd_ptr_r + 1'b1;
      cnt_r <= cnt_r + cnt_w_lp'(push) - cnt_w_lp'(issue);
      if (issue || empty) defer_r <= '0;
      else if (blocked)   defer_r <= defer_r + 1'b1;
    end
  end

  // ---------------- prediction valid ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pv_r <= 1'b0;
    else            pv_r <= bht_r_v_o;
  end

endmodule
